brick_map_ctrl: RTL

BRICK_MAP_CTRL -- requirements
Module: brick_map_ctrl

---
 rtl/brick_map_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/brick_map_ctrl.sv
// Brick-map controller: loads an initial map row by row from ROM, waits for
// a frame start, then arbitrates two rockets' single-brick clear requests.
// Ports:
//   clk, resetN           : clock, async active-low reset
//   start_of_frame        : frame-start pulse (only acted on in WAIT_SOF)
//   new_game, map_sel     : map (re)load request and map index
//   rom_row_addr/_data    : initial-map ROM port (data one cycle after addr)
//   reqN, reqN_row/_col   : rocket clear requests (level), ackN one-cycle ack
//   map_we/wmode/row/col/wdata : brick-map write port
//   map_sel_out, ready    : last loaded map index, high while running
//   hits1/hits2           : saturating per-rocket counts of in-range clears
module brick_map_ctrl #(
  parameter int ROWS  = 15,
  parameter int COLS  = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start_of_frame,
  input  logic             new_game,
  input  logic [1:0]       map_sel,
  output logic [3:0]       rom_row_addr,
  input  logic [COLS-1:0]  rom_row_data,
  input  logic             req1,
  input  logic             req2,
  input  logic [3:0]       req1_row,
  input  logic [3:0]       req2_row,
  input  logic [4:0]       req1_col,
  input  logic [4:0]       req2_col,
  output logic             ack1,
  output logic             ack2,
  output logic             map_we,
  output logic             map_wmode,
  output logic [3:0]       map_row,
  output logic [4:0]       map_col,
  output logic [COLS-1:0]  map_wdata,
  output logic [1:0]       map_sel_out,
  output logic             ready,
  output logic [CNT_W-1:0] hits1,
  output logic [CNT_W-1:0] hits2
);

  typedef enum logic [1:0] {
    IDLE, LOAD, WAIT_SOF, RUN
  } state_t;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t state, state_nx;
  logic   ld_last;
  logic   prio2;
  logic   elig1, elig2;
  logic   gnt1, gnt2;
  logic   in1, in2;
  logic   run_ok;

  // A requester whose ack is showing this cycle sits out one arbitration.
  assign run_ok = (state == RUN) && !new_game;
  assign elig1  = req1 && !ack1;
  assign elig2  = req2 && !ack2;
  assign gnt1   = run_ok && elig1 && (!elig2 || !prio2);
  assign gnt2   = run_ok && elig2 && (!elig1 || prio2);

  assign in1 = (int'(req1_row) < ROWS) && (int'(req1_col) < COLS);
  assign in2 = (int'(req2_row) < ROWS) && (int'(req2_col) < COLS);

  // ROM data arrives in the same cycle the row write strobe is shown.
  assign map_wdata = (map_we && !map_wmode) ? rom_row_data : '0;

  always_comb begin
    state_nx = state;
    if (new_game) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD:     if (ld_last) state_nx = WAIT_SOF;
        WAIT_SOF: if (start_of_frame) state_nx = RUN;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      ld_last      <= 1'b0;
      prio2        <= 1'b0;
      rom_row_addr <= '0;
      ack1         <= 1'b0;
      ack2         <= 1'b0;
      map_we       <= 1'b0;
      map_wmode    <= 1'b0;
      map_row      <= '0;
      map_col      <= '0;
      map_sel_out  <= '0;
      ready        <= 1'b0;
      hits1        <= '0;
      hits2        <= '0;
    end else begin
      state  <= state_nx;
      ready  <= (state_nx == RUN);
      ack1   <= gnt1;
      ack2   <= gnt2;
      map_we <= 1'b0;
      if (new_game) begin
        map_sel_out  <= map_sel;
        rom_row_addr <= '0;
        ld_last      <= 1'b0;
        prio2        <= 1'b0;
        hits1        <= '0;
        hits2        <= '0;
      end else if (state == LOAD) begin
        // ld_last marks the extra cycle that shows the final row write.
        if (!ld_last) begin
          map_we    <= 1'b1;
          map_wmode <= 1'b0;
          map_row   <= rom_row_addr;
          if (rom_row_addr == LAST_ROW) ld_last <= 1'b1;
          else rom_row_addr <= rom_row_addr + 4'd1;
        end
      end else if (gnt1) begin
        map_we    <= in1;
        map_wmode <= 1'b1;
        map_row   <= req1_row;
        map_col   <= req1_col;
        prio2     <= 1'b1;
        if (in1 && hits1 != '1) hits1 <= hits1 + 1'b1;
      end else if (gnt2) begin
        map_we    <= in2;
        map_wmode <= 1'b1;
        map_row   <= req2_row;
        map_col   <= req2_col;
        prio2     <= 1'b0;
        if (in2 && hits2 != '1) hits2 <= hits2 + 1'b1;
      end
    end
  end

endmodule
